// File: rtl/backlight_pixel_comp.sv
// backlight_pixel_comp: boosts RGB by floor(65280/bl) Q8.8 gain, serial divider with one-entry gain cache
module backlight_pixel_comp #(
  parameter int USE_CACHE = 1,
  parameter int SAT_MAX   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  input  logic [7:0]  bl_in,
  input  logic        cache_flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic [15:0] gain_out
);
  typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;
  localparam logic [15:0] DIVIDEND = 16'hFF00;
  state_t state_q, state_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d, bl_q, bl_d;
  logic [7:0] rem_q, rem_d, cached_bl_q, cached_bl_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] quo_q, quo_d, gain_q, gain_d, cached_gain_q, cached_gain_d;
  logic cache_valid_q, cache_valid_d;
  logic [7:0] r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;
  logic [15:0] gain_out_q, gain_out_d;
  logic [8:0] rem_sh;
  logic ge, hit;
  function automatic logic [7:0] sat_ch(input logic [7:0] c, input logic [15:0] g);
    logic [23:0] p;
    p = (24'(c) * 24'(g)) >> 8;
    return (p > 24'(SAT_MAX)) ? 8'(SAT_MAX) : p[7:0];
  endfunction
  // State and datapath registers; reset aborts any in-flight pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      bl_q          <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      quo_q         <= '0;
      gain_q        <= '0;
      cached_bl_q   <= '0;
      cached_gain_q <= '0;
      cache_valid_q <= 1'b0;
      r_out_q       <= '0;
      g_out_q       <= '0;
      b_out_q       <= '0;
      gain_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      bl_q          <= bl_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      quo_q         <= quo_d;
      gain_q        <= gain_d;
      cached_bl_q   <= cached_bl_d;
      cached_gain_q <= cached_gain_d;
      cache_valid_q <= cache_valid_d;
      r_out_q       <= r_out_d;
      g_out_q       <= g_out_d;
      b_out_q       <= b_out_d;
      gain_out_q    <= gain_out_d;
    end
  end
  // Next state; a same-cycle flush forces the miss path
  always_comb begin
    hit     = (USE_CACHE != 0) && cache_valid_q && !cache_flush && (bl_in == cached_bl_q);
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (bl_in == 8'd0 || hit) ? MUL : DIV;
      DIV:  if (cnt_q == 4'd15) state_d = MUL;
      MUL:  state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Datapath: capture, one restoring-divide step per cycle, cache update, channel multiply
  always_comb begin
    rem_sh        = {rem_q, DIVIDEND[~cnt_q]};
    ge            = rem_sh >= {1'b0, bl_q};
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    bl_d          = bl_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    quo_d         = quo_q;
    gain_d        = gain_q;
    cached_bl_d   = cached_bl_q;
    cached_gain_d = cached_gain_q;
    cache_valid_d = cache_flush ? 1'b0 : cache_valid_q;
    r_out_d       = r_out_q;
    g_out_d       = g_out_q;
    b_out_d       = b_out_q;
    gain_out_d    = gain_out_q;
    if (state_q == IDLE && in_valid) begin
      r_d    = r_in;
      g_d    = g_in;
      b_d    = b_in;
      bl_d   = bl_in;
      rem_d  = '0;
      cnt_d  = '0;
      quo_d  = '0;
      gain_d = (bl_in == 8'd0) ? 16'd0 : cached_gain_q;
    end
    if (state_q == DIV) begin
      rem_d = ge ? 8'(rem_sh - {1'b0, bl_q}) : rem_sh[7:0];
      quo_d = {quo_q[14:0], ge};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        gain_d        = quo_d;
        cached_gain_d = quo_d;
        cached_bl_d   = bl_q;
        cache_valid_d = 1'b1;
      end
    end
    if (state_q == MUL) begin
      r_out_d    = sat_ch(r_q, gain_q);
      g_out_d    = sat_ch(g_q, gain_q);
      b_out_d    = sat_ch(b_q, gain_q);
      gain_out_d = gain_q;
    end
  end
  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == OUT;
    r_out     = r_out_q;
    g_out     = g_out_q;
    b_out     = b_out_q;
    gain_out  = gain_out_q;
  end
endmodule

// File: doc/backlight_pixel_comp.md
Name: backlight_pixel_comp

Overview:
- Display-side counterpart of the RGB-to-gray/backlight extraction path.
- The extraction path measures pixel luminance to choose a dimmed zone backlight level. This block takes each pixel plus its zone's backlight level and boosts the RGB so perceived brightness is restored: out = min(255, c*255/bl).
- Sits between the zone-level memory/pixel stream and the panel output formatter.
- Valid/ready on both sides. Uses a serial restoring divider with a one-entry gain cache, so runs of pixels in the same zone cost 1 cycle of compute.

Parameters:
- USE_CACHE, 1, 1 = reuse the last computed gain when bl matches; 0 = divide on every pixel.
- SAT_MAX, 255, output saturation ceiling per channel (8-bit value).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- r_in  in  8  red component, 0..255.
- g_in  in  8  green component, 0..255.
- b_in  in  8  blue component, 0..255.
- bl_in  in  8  zone backlight level, 0..255.
- cache_flush  in  1  single-cycle pulse; invalidates the gain cache (frame start).
- out_valid  out  1  compensated pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- r_out  out  8  compensated red.
- g_out  out  8  compensated green.
- b_out  out  8  compensated blue.
- gain_out  out  16  Q8.8 gain used for the current output pixel (debug).

Behaviour:
- Reset (async, immediate):
  - state=IDLE, in_ready=1, out_valid=0.
  - r_out/g_out/b_out=0, gain_out=0.
  - Cache invalid, divider registers cleared.
  - Reset mid-operation aborts and discards the in-flight pixel.
- Gain: gain = floor(65280/bl), a 16-bit Q8.8 value.
  - bl=255 gives gain 256 (unity); bl=1 gives 65280.
  - bl=0: gain forced to 0 (black output). No divide, cache untouched.
- Channel arithmetic: p = c*gain (24-bit); res = p>>8; out = (res>SAT_MAX) ? SAT_MAX : res[7:0]. Truncation, no rounding.
- FSM states: IDLE, DIV, MUL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register r/g/b/bl.
  - If bl==0 → MUL.
  - Else if USE_CACHE && cache_valid && bl==cached_bl → MUL.
  - Else → DIV.
- DIV:
  - Restoring division, dividend 65280, divisor bl; one quotient bit per cycle, MSB first, exactly 16 cycles.
  - On the last cycle: write gain to the cache, set cached_bl=bl and cache_valid=1, → MUL.
- MUL:
  - One cycle: compute all three channels plus gain_out and register them.
  - Set out_valid=1, → OUT.
- OUT:
  - Outputs held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0, → IDLE.
- in_ready is 0 in DIV/MUL/OUT. One pixel in flight; no input skid buffer.
- Latency, counted from the acceptance edge:
  - Hit or bl=0: out_valid high after 1 edge.
  - Miss: out_valid high after 17 edges.
  - Minimum hit throughput: 1 pixel per 3 cycles with out_ready held at 1.
- cache_flush:
  - Clears cache_valid at the next edge in any state.
  - A DIV in progress still completes and refills the cache on its last cycle. If flush and that last cycle coincide, the refill wins.
  - A flush in the same cycle as an IDLE acceptance is applied first, so that pixel takes the miss path.
- in_valid while in_ready=0 is ignored; upstream holds data.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset with in_valid=0 → in_ready=1, out_valid=0, all outputs 0. Assert reset during DIV → return to IDLE, no output pixel emitted.
- Pixel r=100,g=50,b=255, bl=255 (cold cache) → out_valid 17 edges after accept; gain_out=256; rgb=100,50,255.
- bl=128, r=100,g=200,b=0 → gain_out=510; rgb=199,255(saturated),0. Second pixel, same bl, r=10 → hit path, out_valid 1 edge after accept; r_out=19.
- bl=0, r=g=b=200 → 1-edge latency, rgb=0,0,0, gain_out=0. A following pixel with bl=128 still hits the cached gain 510.
- out_ready held 0 for 5 cycles after out_valid → outputs stable, in_ready=0 throughout; accept resumes the cycle after the out_ready handshake.
- cache_flush pulse in the same cycle as acceptance of a bl=128 pixel → miss path, 17-edge latency. Randomised check against the reference formula for all bl in 1..255.
